// File: rtl/core_hazard_ctrl.sv
// Pipeline sequencing controller: picks advance/stall/flush for IF/ID/EX and the next-PC source,
// tracks the iterative MDU busy window, and keeps stall/redirect performance counters.
module core_hazard_ctrl #(
    parameter int MDU_CYCLES = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_B_is_reg,
    input  logic        id_mdu_use,
    input  logic        ex_mem_read,
    input  logic        ex_write_enable,
    input  logic [4:0]  ex_W_regnum,
    input  logic        ex_mdu_start,
    input  logic        ex_redirect,
    input  logic        mem_exception,
    input  logic        mem_eret,
    output logic        hold_IF,
    output logic        flush_IF,
    output logic        stall_ID,
    output logic        flush_ID,
    output logic        flush_EX,
    output logic [1:0]  pc_sel,
    output logic        mdu_busy,
    output logic [31:0] stall_cycles,
    output logic [31:0] redirect_count
);
    typedef enum logic {RUN, EXC} state_t;

    localparam logic [5:0] MDU_LOAD = 6'(MDU_CYCLES - 1);

    state_t      state, state_nxt;
    logic [5:0]  mdu_cnt;
    logic [31:0] stall_cnt;
    logic [31:0] redir_cnt;
    logic        load_use;
    logic        mdu_haz;
    logic        hazard;

    assign mdu_busy = (mdu_cnt != 6'd0);
    assign load_use = ex_mem_read & ex_write_enable & (ex_W_regnum != 5'd0) &
                      ((ex_W_regnum == id_rs) | (id_B_is_reg & (ex_W_regnum == id_rt)));
    assign mdu_haz  = mdu_busy & id_mdu_use;
    assign hazard   = mdu_haz | load_use;

    always_ff @(posedge clock) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    // Redirects outrank stalls, so a flushed cycle never also holds IF or bubbles ID.
    always_comb begin
        state_nxt = RUN;
        hold_IF   = 1'b0;
        flush_IF  = 1'b0;
        stall_ID  = 1'b0;
        flush_ID  = 1'b0;
        flush_EX  = 1'b0;
        pc_sel    = 2'd0;
        if (state == RUN && (mem_exception || mem_eret)) begin
            flush_IF  = 1'b1;
            flush_ID  = 1'b1;
            flush_EX  = 1'b1;
            pc_sel    = mem_exception ? 2'd2 : 2'd3;
            state_nxt = EXC;
        end else if (state == RUN && ex_redirect) begin
            flush_IF = 1'b1;
            flush_ID = 1'b1;
            pc_sel   = 2'd1;
        end else if (hazard) begin
            // EXC only masks redirects; MEM/EX hold bubbles but ID hazards stay live.
            hold_IF  = 1'b1;
            stall_ID = 1'b1;
        end
    end

    // An in-flight MDU op is older than any faulting instruction, so it is never aborted.
    always_ff @(posedge clock) begin
        if (reset)                         mdu_cnt <= 6'd0;
        else if (ex_mdu_start && !flush_EX) mdu_cnt <= MDU_LOAD;
        else if (mdu_cnt != 6'd0)          mdu_cnt <= mdu_cnt - 6'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt <= 32'd0;
            redir_cnt <= 32'd0;
        end else begin
            if (stall_ID)        stall_cnt <= stall_cnt + 32'd1;
            if (pc_sel != 2'd0)  redir_cnt <= redir_cnt + 32'd1;
        end
    end

    assign stall_cycles   = stall_cnt;
    assign redirect_count = redir_cnt;
endmodule

// File: tb/tb_core_hazard_ctrl.sv
// Directed bench for core_hazard_ctrl: hazards, redirects, EXC shadow, MDU window, reset, counter wrap.
module tb_core_hazard_ctrl;
    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_W_regnum;
    logic        id_B_is_reg, id_mdu_use, ex_mem_read, ex_write_enable;
    logic        ex_mdu_start, ex_redirect, mem_exception, mem_eret;
    logic        hold_IF, flush_IF, stall_ID, flush_ID, flush_EX, mdu_busy;
    logic [1:0]  pc_sel;
    logic [31:0] stall_cycles, redirect_count;

    int total = 0;
    int bad   = 0;

    core_hazard_ctrl #(.MDU_CYCLES(4)) dut (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_B_is_reg(id_B_is_reg), .id_mdu_use(id_mdu_use),
        .ex_mem_read(ex_mem_read), .ex_write_enable(ex_write_enable), .ex_W_regnum(ex_W_regnum),
        .ex_mdu_start(ex_mdu_start), .ex_redirect(ex_redirect),
        .mem_exception(mem_exception), .mem_eret(mem_eret),
        .hold_IF(hold_IF), .flush_IF(flush_IF), .stall_ID(stall_ID), .flush_ID(flush_ID),
        .flush_EX(flush_EX), .pc_sel(pc_sel), .mdu_busy(mdu_busy),
        .stall_cycles(stall_cycles), .redirect_count(redirect_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_B_is_reg = 1'b0; id_mdu_use = 1'b0;
        ex_mem_read = 1'b0; ex_write_enable = 1'b0; ex_W_regnum = 5'd0;
        ex_mdu_start = 1'b0; ex_redirect = 1'b0; mem_exception = 1'b0; mem_eret = 1'b0;
    endtask

    task automatic load_use_r8();
        ex_mem_read = 1'b1; ex_write_enable = 1'b1; ex_W_regnum = 5'd8; id_rs = 5'd8;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic next_cycle();
        @(negedge clock);
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_hold", {31'd0, hold_IF}, 32'd0);
        chk("rst_stall", {31'd0, stall_ID}, 32'd0);
        chk("rst_pcsel", {30'd0, pc_sel}, 32'd0);
        chk("rst_busy", {31'd0, mdu_busy}, 32'd0);
        chk("rst_stallcnt", stall_cycles, 32'd0);
        chk("rst_redircnt", redirect_count, 32'd0);

        // Load-use on rs
        next_cycle(); load_use_r8(); #1;
        chk("lu_hold", {31'd0, hold_IF}, 32'd1);
        chk("lu_stall", {31'd0, stall_ID}, 32'd1);
        // Destination r0 never hazards
        next_cycle(); load_use_r8(); ex_W_regnum = 5'd0; id_rs = 5'd0; #1;
        chk("lu_stallcnt1", stall_cycles, 32'd1);
        chk("lu_r0_stall", {31'd0, stall_ID}, 32'd0);
        // rt match only counts when rt is really read
        next_cycle(); load_use_r8(); id_rs = 5'd3; id_rt = 5'd8; #1;
        chk("lu_rt_unused", {31'd0, stall_ID}, 32'd0);
        next_cycle(); load_use_r8(); id_rs = 5'd3; id_rt = 5'd8; id_B_is_reg = 1'b1; #1;
        chk("lu_rt_used", {31'd0, stall_ID}, 32'd1);
        // Non-load writer does not stall
        next_cycle(); load_use_r8(); ex_mem_read = 1'b0; #1;
        chk("lu_noload", {31'd0, stall_ID}, 32'd0);
        chk("lu_stallcnt2", stall_cycles, 32'd2);

        // MDU window with MDU_CYCLES=4: busy in cycles 1..3
        next_cycle(); ex_mdu_start = 1'b1; #1;
        chk("mdu_c0_busy", {31'd0, mdu_busy}, 32'd0);
        for (int c = 1; c <= 3; c++) begin
            next_cycle(); id_mdu_use = 1'b1; #1;
            chk($sformatf("mdu_c%0d_busy", c), {31'd0, mdu_busy}, 32'd1);
            chk($sformatf("mdu_c%0d_stall", c), {31'd0, stall_ID}, 32'd1);
        end
        next_cycle(); id_mdu_use = 1'b1; #1;
        chk("mdu_c4_busy", {31'd0, mdu_busy}, 32'd0);
        chk("mdu_c4_stall", {31'd0, stall_ID}, 32'd0);
        chk("mdu_stallcnt", stall_cycles, 32'd5);

        // Branch beats a load-use stall
        next_cycle(); load_use_r8(); ex_redirect = 1'b1; #1;
        chk("br_flushIF", {31'd0, flush_IF}, 32'd1);
        chk("br_flushID", {31'd0, flush_ID}, 32'd1);
        chk("br_flushEX", {31'd0, flush_EX}, 32'd0);
        chk("br_hold", {31'd0, hold_IF}, 32'd0);
        chk("br_stall", {31'd0, stall_ID}, 32'd0);
        chk("br_pcsel", {30'd0, pc_sel}, 32'd1);

        // Exception + ERET + branch; MDU start in a flushed EX must not load
        next_cycle(); mem_exception = 1'b1; mem_eret = 1'b1; ex_redirect = 1'b1; ex_mdu_start = 1'b1; #1;
        chk("br_redircnt", redirect_count, 32'd1);
        chk("br_stallcnt", stall_cycles, 32'd5);
        chk("exc_pcsel", {30'd0, pc_sel}, 32'd2);
        chk("exc_flushes", {29'd0, flush_IF, flush_ID, flush_EX}, 32'd7);
        // EXC shadow: redirects ignored, hazards still live
        next_cycle(); mem_exception = 1'b1; ex_redirect = 1'b1; load_use_r8(); #1;
        chk("shadow_pcsel", {30'd0, pc_sel}, 32'd0);
        chk("shadow_flushes", {29'd0, flush_IF, flush_ID, flush_EX}, 32'd0);
        chk("shadow_stall", {31'd0, stall_ID}, 32'd1);
        chk("shadow_busy", {31'd0, mdu_busy}, 32'd0);
        chk("exc_redircnt", redirect_count, 32'd2);
        // Back in RUN: ERET alone selects EPC
        next_cycle(); mem_eret = 1'b1; #1;
        chk("eret_pcsel", {30'd0, pc_sel}, 32'd3);
        chk("eret_flushEX", {31'd0, flush_EX}, 32'd1);
        chk("shadow_stallcnt", stall_cycles, 32'd6);
        // EXC again; MDU start here is not flushed and loads
        next_cycle(); ex_mdu_start = 1'b1; mem_exception = 1'b1; #1;
        chk("shadow2_pcsel", {30'd0, pc_sel}, 32'd0);
        chk("eret_redircnt", redirect_count, 32'd3);
        next_cycle(); #1;
        chk("shadow_mdu_busy", {31'd0, mdu_busy}, 32'd1);

        // Reset in the middle of an MDU op
        next_cycle(); reset = 1'b1; #1;
        chk("mid_busy", {31'd0, mdu_busy}, 32'd1);
        next_cycle(); reset = 1'b0; #1;
        chk("mrst_busy", {31'd0, mdu_busy}, 32'd0);
        chk("mrst_stallcnt", stall_cycles, 32'd0);
        chk("mrst_redircnt", redirect_count, 32'd0);
        chk("mrst_pcsel", {30'd0, pc_sel}, 32'd0);

        // Wrap: preload stall counter to all-ones, then one stall
        next_cycle();
        force dut.stall_cnt = 32'hFFFF_FFFF;
        #1 release dut.stall_cnt;
        load_use_r8(); #1;
        chk("wrap_pre", stall_cycles, 32'hFFFF_FFFF);
        chk("wrap_stall", {31'd0, stall_ID}, 32'd1);
        next_cycle(); #1;
        chk("wrap_post", stall_cycles, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/core_hazard_ctrl.md
# core_hazard_ctrl

Pipeline sequencing controller for the IF/ID/EX/MEM core. It decides each cycle whether the front end advances, stalls or is flushed, and it selects the next-PC source. It drives the `stall`/`flush` inputs of the decode stage and the hold/flush controls of fetch and EX. Load-use detection, the iterative multiply/divide busy window, branch redirects, and exception/ERET redirects are handled with fixed priorities. Two 32-bit performance counters are included.

## Interface
- MDU_CYCLES, 32: total latency of the iterative multiply/divide unit, from start to result available. Legal range 2..64.
- clock  in  1  core clock.
- reset  in  1  synchronous, active-high.
- id_rs  in  5  source register A of the instruction in ID.
- id_rt  in  5  source register B of the instruction in ID.
- id_B_is_reg  in  1  id_rt is actually read.
- id_mdu_use  in  1  ID instruction reads HI/LO or starts an MDU op.
- ex_mem_read  in  1  EX instruction is a load.
- ex_write_enable  in  1  EX instruction writes the regfile.
- ex_W_regnum  in  5  EX destination register.
- ex_mdu_start  in  1  EX instruction launches an MDU op this cycle.
- ex_redirect  in  1  EX resolved a taken branch or jump.
- mem_exception  in  1  exception taken at MEM.
- mem_eret  in  1  ERET committing at MEM.
- hold_IF  out  1  PC and IF_regs keep their value.
- flush_IF  out  1  IF_regs cleared to a bubble.
- stall_ID  out  1  ID inserts a bubble into ID_regs.
- flush_ID  out  1  ID_regs cleared (wrong-path instruction).
- flush_EX  out  1  EX/MEM register cleared.
- pc_sel  out  2  next-PC source: 0 sequential, 1 branch/jump target, 2 exception vector, 3 EPC.
- mdu_busy  out  1  MDU result not yet available.
- stall_cycles  out  32  number of cycles in which stall_ID was asserted.
- redirect_count  out  32  number of redirects (branch, exception or ERET).

## Operation
**States**
- RUN: normal operation.
- EXC: a one-cycle shadow after an exception or ERET redirect.

**Priority in RUN** (highest first; all outputs are combinational from state and inputs):
1. mem_exception or mem_eret.
   - flush_IF=flush_ID=flush_EX=1.
   - pc_sel=2 for an exception, 3 for ERET; exception wins if both are high.
   - Next state is EXC.
2. ex_redirect.
   - flush_IF=flush_ID=1, pc_sel=1.
3. MDU hazard: mdu_busy & id_mdu_use.
   - hold_IF=1, stall_ID=1.
4. Load-use hazard: ex_mem_read & ex_write_enable & ex_W_regnum≠0 & (ex_W_regnum==id_rs | (id_B_is_reg & ex_W_regnum==id_rt)).
   - hold_IF=1, stall_ID=1.
5. Otherwise all controls are 0 and pc_sel=0.

**Override rules**
- Any flush forces hold_IF=0 and stall_ID=0.

**EXC state**
- All controls 0, pc_sel=0.
- mem_exception, mem_eret and ex_redirect are ignored, because those stages hold flushed bubbles.
- Hazard stalls are still evaluated.
- Returns to RUN after one cycle.

**MDU counter** (6-bit)
- Loaded with MDU_CYCLES-1 on any cycle where ex_mdu_start=1 and EX is not flushed that cycle. This applies in both states.
- Otherwise decrements while nonzero.
- mdu_busy = (counter≠0).
- An exception does not abort an MDU op already in flight, because it is older than the faulting instruction.
- ex_mdu_start while busy reloads the counter. Decode normally prevents this case.

**Performance counters**
- stall_cycles increments on every cycle with stall_ID=1.
- redirect_count increments on every cycle with pc_sel≠0.
- Both wrap modulo 2^32.

## Timing
- Reset sets: state RUN, MDU counter 0, mdu_busy 0, stall_cycles 0, redirect_count 0, all controls 0, pc_sel 0.
- Reset applied during an MDU op or in EXC clears everything on the next edge.
- Hazard and flush outputs act in the same cycle as their causing inputs; there are no registered controls.
- Load-use causes exactly one bubble. The next cycle the load is in MEM and decode forwarding supplies the data.
- MDU start in cycle t: mdu_busy is high in cycles t+1 through t+MDU_CYCLES-1. A consumer in ID is released in cycle t+MDU_CYCLES.
- Counter updates are visible the cycle after the event.

## Test plan
- Load-use: ex_mem_read=1, ex_write_enable=1, ex_W_regnum=8, id_rs=8.
  - Required: hold_IF=stall_ID=1 that cycle; stall_cycles 0→1.
  - Repeat with ex_W_regnum=0: no stall.
  - Repeat with id_rt=8 and id_B_is_reg=0: no stall.
- MDU: MDU_CYCLES=4, ex_mdu_start at cycle 0, id_mdu_use=1 from cycle 1.
  - Required: mdu_busy and stall_ID high in cycles 1–3, low in cycle 4; stall_cycles=3.
- Branch over hazard: ex_redirect=1 together with a load-use match.
  - Required: flush_IF=flush_ID=1, hold_IF=stall_ID=0, pc_sel=1; redirect_count +1.
- Exception with branch: mem_exception=1, mem_eret=1 and ex_redirect=1 together.
  - Required: pc_sel=2 and all three flushes.
  - Next cycle, with mem_exception=1 still driven: pc_sel=0 and no flush (EXC state); RUN the cycle after.
- Reset mid-MDU: reset at cycle 2 of a 32-cycle op.
  - Required: next cycle mdu_busy=0, both counters 0, pc_sel=0.
- Counter wrap: force stall_cycles to 0xFFFFFFFF via 2^32-1 stalls or a backdoor, then one stall cycle.
  - Required: stall_cycles reads 0.
